// File: rtl/jt51_phrom_pkg.sv
// rtl/jt51_phrom_pkg.sv - shared widths, owner and sweep-state types for the phase-ROM arbiter
package jt51_phrom_pkg;

  localparam int PH_W   = 19;
  localparam int ADDR_W = 5;
  localparam int BANK_W = 2;
  localparam int IDX_W  = BANK_W + ADDR_W;

  typedef enum logic {
    OWN_OP  = 1'b0,
    OWN_AUX = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_ISSUE,
    SW_WAIT,
    SW_DONE
  } sweep_state_e;

  // Rotate-left-by-one then fold in the new word.
  function automatic logic [PH_W-1:0] sig_step(input logic [PH_W-1:0] sig,
                                               input logic [PH_W-1:0] ph);
    return {sig[PH_W-2:0], sig[PH_W-1]} ^ ph;
  endfunction

endpackage

// File: rtl/jt51_phrom_arb_if.sv
// rtl/jt51_phrom_arb_if.sv - operator and auxiliary requester bus of the phase-ROM arbiter
interface jt51_phrom_arb_if #(
  parameter int TAG_W = 5
);
  import jt51_phrom_pkg::*;

  logic              op_req;
  logic [BANK_W-1:0] op_bank;
  logic [ADDR_W-1:0] op_addr;
  logic [TAG_W-1:0]  op_tag;
  logic              op_vld;
  logic [PH_W-1:0]   op_ph;
  logic [TAG_W-1:0]  op_tag_out;

  logic              aux_req;
  logic              aux_ready;
  logic [BANK_W-1:0] aux_bank;
  logic [ADDR_W-1:0] aux_addr;
  logic              aux_rvld;
  logic [PH_W-1:0]   aux_ph;
  logic              aux_rack;

  modport master (
    output op_req, op_bank, op_addr, op_tag,
    output aux_req, aux_bank, aux_addr, aux_rack,
    input  op_vld, op_ph, op_tag_out,
    input  aux_ready, aux_rvld, aux_ph
  );

  modport slave (
    input  op_req, op_bank, op_addr, op_tag,
    input  aux_req, aux_bank, aux_addr, aux_rack,
    output op_vld, op_ph, op_tag_out,
    output aux_ready, aux_rvld, aux_ph
  );

endinterface

// File: rtl/jt51_phrom_sweep.sv
// rtl/jt51_phrom_sweep.sv - walks all 128 ROM words through the aux port and folds them into a signature
module jt51_phrom_sweep
  import jt51_phrom_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              start,
  input  logic              gnt,
  input  logic              res_vld,
  input  logic [PH_W-1:0]   res_ph,
  output logic              req,
  output logic [BANK_W-1:0] bank,
  output logic [ADDR_W-1:0] addr,
  output logic              ack,
  output logic              res_own,
  output logic              busy,
  output logic              done,
  output logic [PH_W-1:0]   sig
);

  sweep_state_e     state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [PH_W-1:0]  sig_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SW_IDLE;
      idx   <= '0;
      sig   <= '0;
    end else if (cen) begin
      state <= state_n;
      idx   <= idx_n;
      sig   <= sig_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    sig_n   = sig;
    req     = 1'b0;
    ack     = 1'b0;
    case (state)
      SW_IDLE: begin
        if (start) begin
          state_n = SW_ISSUE;
          idx_n   = '0;
          sig_n   = '0;
        end
      end
      SW_ISSUE: begin
        req = 1'b1;
        if (gnt) state_n = SW_WAIT;
      end
      SW_WAIT: begin
        if (res_vld) begin
          ack     = 1'b1;
          sig_n   = sig_step(sig, res_ph);
          idx_n   = idx + 1'b1;
          state_n = (&idx) ? SW_DONE : SW_ISSUE;
        end
      end
      SW_DONE: state_n = SW_IDLE;
      default: state_n = SW_IDLE;
    endcase
  end

  assign bank    = idx[IDX_W-1:ADDR_W];
  assign addr    = idx[ADDR_W-1:0];
  // Only the result requested from WAIT belongs to the sweep; others stay with the external port.
  assign res_own = (state == SW_WAIT);
  assign busy    = (state != SW_IDLE);
  assign done    = (state == SW_DONE) & cen;

endmodule

// File: rtl/jt51_phrom_arb.sv
// rtl/jt51_phrom_arb.sv - operator/aux arbiter for the shared phase ROM with tagged result steering
// Optional address sweep signature engine enabled by JT51_PHROM_SWEEP_EN.
module jt51_phrom_arb
  import jt51_phrom_pkg::*;
#(
  parameter int STALL_W = 8,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  jt51_phrom_arb_if.slave    bus,
  output logic [BANK_W-1:0]  rom_bank,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [PH_W-1:0]    rom_ph,
  output logic [STALL_W-1:0] aux_stall
`ifdef JT51_PHROM_SWEEP_EN
  ,
  input  logic               sweep_start,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic [PH_W-1:0]    sweep_sig
`endif
);

  logic              aux_req_i;
  logic [BANK_W-1:0] aux_bank_i;
  logic [ADDR_W-1:0] aux_addr_i;
  logic              aux_rack_i;
  logic              ext_block;

  logic              s1_vld;
  owner_e            s1_own;
  logic [TAG_W-1:0]  s1_tag;

  logic              aux_outstanding;
  logic              aux_free;
  logic              aux_gnt;

  assign aux_outstanding = (s1_vld && (s1_own == OWN_AUX)) || bus.aux_rvld;
  assign aux_free        = cen & ~rst & ~bus.op_req & ~aux_outstanding;
  assign aux_gnt         = aux_free & aux_req_i;
  assign bus.aux_ready   = aux_free & ~ext_block;

`ifdef JT51_PHROM_SWEEP_EN
  logic              sw_req;
  logic [BANK_W-1:0] sw_bank;
  logic [ADDR_W-1:0] sw_addr;
  logic              sw_ack;
  logic              sw_own;

  jt51_phrom_sweep u_sweep (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .start   (sweep_start),
    .gnt     (aux_gnt),
    .res_vld (bus.aux_rvld),
    .res_ph  (bus.aux_ph),
    .req     (sw_req),
    .bank    (sw_bank),
    .addr    (sw_addr),
    .ack     (sw_ack),
    .res_own (sw_own),
    .busy    (sweep_busy),
    .done    (sweep_done),
    .sig     (sweep_sig)
  );

  assign ext_block  = sweep_busy;
  assign aux_req_i  = sweep_busy ? sw_req  : bus.aux_req;
  assign aux_bank_i = sweep_busy ? sw_bank : bus.aux_bank;
  assign aux_addr_i = sweep_busy ? sw_addr : bus.aux_addr;
  assign aux_rack_i = sw_own ? sw_ack : bus.aux_rack;
`else
  assign ext_block  = 1'b0;
  assign aux_req_i  = bus.aux_req;
  assign aux_bank_i = bus.aux_bank;
  assign aux_addr_i = bus.aux_addr;
  assign aux_rack_i = bus.aux_rack;
`endif

  // Stage 1: grant and register the ROM address; the operator never waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_bank <= '0;
      rom_addr <= '0;
      s1_vld   <= 1'b0;
      s1_own   <= OWN_OP;
      s1_tag   <= '0;
    end else if (cen) begin
      if (bus.op_req) begin
        rom_bank <= bus.op_bank;
        rom_addr <= bus.op_addr;
        s1_vld   <= 1'b1;
        s1_own   <= OWN_OP;
        s1_tag   <= bus.op_tag;
      end else if (aux_gnt) begin
        rom_bank <= aux_bank_i;
        rom_addr <= aux_addr_i;
        s1_vld   <= 1'b1;
        s1_own   <= OWN_AUX;
        s1_tag   <= bus.op_tag;
      end else begin
        s1_vld   <= 1'b0;
      end
    end
  end

  // Stage 2: steer the ROM word to whoever owned stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.op_vld     <= 1'b0;
      bus.op_ph      <= '0;
      bus.op_tag_out <= '0;
      bus.aux_rvld   <= 1'b0;
      bus.aux_ph     <= '0;
      aux_stall      <= '0;
    end else if (cen) begin
      bus.op_vld <= s1_vld && (s1_own == OWN_OP);
      if (s1_vld && (s1_own == OWN_OP)) begin
        bus.op_ph      <= rom_ph;
        bus.op_tag_out <= s1_tag;
      end
      if (s1_vld && (s1_own == OWN_AUX)) begin
        bus.aux_ph   <= rom_ph;
        bus.aux_rvld <= 1'b1;
      end else if (aux_rack_i) begin
        bus.aux_rvld <= 1'b0;
      end
      if (aux_req_i && !aux_outstanding && bus.op_req && !(&aux_stall))
        aux_stall <= aux_stall + 1'b1;
    end
  end

endmodule
